vend_credit_fsm: RTL and testbench
==================================

VEND_CREDIT_FSM -- requirements
Module: vend_credit_fsm

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, SHALL set the number of cycles a vend state (credit 5..8) is held before the credit returns to 0; legal range 1..15.
REQ-002 clk  in  1  single system clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 coin_valid  in  1  coin offered this cycle.
REQ-005 coin_type  in  2  coin value: 00 quarter (1 unit), 01 half (2 units), 10 dollar (4 units), 11 invalid.
REQ-006 coin_ready  out  1  block accepts a coin this cycle; a coin is consumed only when coin_valid and coin_ready are both 1.
REQ-007 coin_reject  out  1  one-cycle pulse: an invalid coin was consumed and discarded.
REQ-008 cancel_req  in  1  customer cancel request; present only with CANCEL_EN.
REQ-009 refund_valid  out  1  one-cycle pulse: refund_units is valid.
REQ-010 refund_units  out  3  units refunded on cancel, range 0..4.
REQ-011 credit_state  out  4  current credit in quarter units, range 0..8; drives the downstream item/change decode.
REQ-012 vend_busy  out  1  high while credit_state is in 5..8.

Function
REQ-013 The block SHALL have three states: COLLECT (credit 0..4), VEND (credit 5..8), and REFUND (only with CANCEL_EN).
REQ-014 In COLLECT, coin_ready SHALL be 1; in VEND and REFUND, coin_ready SHALL be 0.
REQ-015 Each accepted valid coin SHALL add its unit value to credit in the same edge, so credit_state reflects the coin one cycle after acceptance.
REQ-016 Because credit is at most 4 and the largest coin is 4, the new credit is at most 8; no saturation logic is needed, and a 4-bit sum SHALL be used.
REQ-017 If the new credit is 5 or more, the block SHALL enter VEND and load the hold counter with HOLD_CYCLES-1.
REQ-018 An accepted coin of type 11 SHALL leave credit unchanged and pulse coin_reject for exactly one cycle, registered and coincident with the next credit_state update.
REQ-019 In VEND, credit_state SHALL hold constant while the counter decrements once per cycle.
REQ-020 When the counter reaches 0, the next edge SHALL set credit to 0 and return to COLLECT.
REQ-021 credit_state SHALL therefore show each vend value for exactly HOLD_CYCLES cycles.
REQ-022 An exact-price coin (credit 4 plus a quarter, giving 5) and an overpay (credit 4 plus a dollar, giving 8) SHALL both follow REQ-017; change is derived downstream.
REQ-023 coin_valid while coin_ready is 0 SHALL be ignored with no reject pulse; the upstream source holds the coin.
REQ-024 vend_busy SHALL be the registered decode of the VEND state, never combinational from the inputs.

Reset
REQ-025 On rst=1 at an edge, the block SHALL set the state to COLLECT, credit_state=0, the hold counter=0, coin_reject=0, refund_valid=0, and refund_units=0.
REQ-026 Reset SHALL override any concurrent coin, cancel, or vend hold.
REQ-027 Reset in VEND SHALL abort the vend with no refund.

Configuration
REQ-028 With VEND_CANCEL_EN defined, cancel_req in COLLECT SHALL move the block to REFUND and capture refund_units=credit.
REQ-029 REFUND SHALL last one cycle, pulse refund_valid, set credit to 0, and return to COLLECT.
REQ-030 If cancel_req and an accepted coin occur in the same cycle, cancel SHALL win and the coin SHALL NOT be consumed (coin_ready forced to 0 that cycle).
REQ-031 cancel_req SHALL be ignored in VEND.
REQ-032 Cancel at credit 0 SHALL still pulse refund_valid with refund_units=0.
REQ-033 Without VEND_CANCEL_EN, the cancel_req port and REFUND state SHALL be absent, and refund_valid and refund_units SHALL be tied to 0.

Structure
REQ-034 The shared package vend_pkg SHALL hold the state enum (COLLECT, VEND, REFUND), the coin_type encoding constants, PRICE_UNITS=5, and MAX_CREDIT=8.
REQ-035 The sub-module coin_value_decode SHALL map coin_type to a 3-bit unit value plus an invalid flag.
REQ-036 The FSM, hold counter, and refund register SHALL reside in vend_credit_fsm.

Verification
REQ-037 Reset, then five quarters on consecutive cycles -> credit 1,2,3,4,5; vend_busy=1 for 4 cycles at 5; then credit=0 and coin_ready=1.
REQ-038 Dollar then dollar -> credit 4 then 8; vend hold for HOLD_CYCLES; a coin offered during VEND is not accepted and credit stays 8.
REQ-039 Half, then coin_type 11, then half -> credit 2, coin_reject pulse with credit still 2, then credit 4.
REQ-040 (VEND_CANCEL_EN) Quarter, half, then cancel_req with a simultaneous quarter -> refund_units=3, refund_valid for 1 cycle, credit 0, quarter not consumed.
REQ-041 rst asserted on the 2nd VEND cycle at credit 7 -> next cycle credit 0, vend_busy 0, no refund pulse.
REQ-042 HOLD_CYCLES=1, half+half+half -> credit 6 for exactly 1 cycle, then 0.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared state encoding, coin encodings and pricing constants
//               for the vending credit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        REFUND  = 2'd2
    } vend_state_t;

    localparam logic [1:0] COIN_QUARTER = 2'b00;
    localparam logic [1:0] COIN_HALF    = 2'b01;
    localparam logic [1:0] COIN_DOLLAR  = 2'b10;
    localparam logic [1:0] COIN_INVALID = 2'b11;

    localparam logic [3:0] PRICE_UNITS  = 4'd5;
    localparam logic [3:0] MAX_CREDIT   = 4'd8;

endpackage
`default_nettype wire

// File: rtl/coin_value_decode.sv
`default_nettype none
// ============================================================================
// Module      : coin_value_decode
// Description : Maps a coin_type code to its value in quarter units and
//               flags the unused code as invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_value_decode
    import vend_pkg::*;
(
    input  logic [1:0] coin_type,
    output logic [2:0] unit_value,
    output logic       invalid
);

    always_comb begin
        unit_value = 3'd0;
        invalid    = 1'b0;
        case (coin_type)
            COIN_QUARTER: unit_value = 3'd1;
            COIN_HALF:    unit_value = 3'd2;
            COIN_DOLLAR:  unit_value = 3'd4;
            default:      invalid    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vend_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vend_credit_fsm
// Description : Coin credit accumulator; holds a vend credit for HOLD_CYCLES
//               cycles, then clears. Define VEND_CANCEL_EN for cancel/refund.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_ready,
    output logic       coin_reject,
`ifdef VEND_CANCEL_EN
    input  logic       cancel_req,
`endif
    output logic       refund_valid,
    output logic [2:0] refund_units,
    output logic [3:0] credit_state,
    output logic       vend_busy
);

    localparam logic [3:0] c_HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    vend_state_t r_state, w_next_state;
    logic [3:0]  r_credit, w_next_credit;
    logic [3:0]  r_hold, w_next_hold;
    logic        r_reject, w_next_reject;
    logic        r_busy;
    logic        w_coin_ready;
    logic [2:0]  w_unit_value;
    logic        w_invalid;
    logic [3:0]  w_sum;

    coin_value_decode u_decode (
        .coin_type  (coin_type),
        .unit_value (w_unit_value),
        .invalid    (w_invalid)
    );

    // Credit never exceeds 4 in COLLECT, so the sum tops out at 8.
    assign w_sum = r_credit + {1'b0, w_unit_value};

`ifdef VEND_CANCEL_EN
    logic       r_refund_valid, w_next_refund_valid;
    logic [2:0] r_refund_units, w_next_refund_units;
`endif

    always_comb begin
        w_next_state  = r_state;
        w_next_credit = r_credit;
        w_next_hold   = r_hold;
        w_next_reject = 1'b0;
        w_coin_ready  = 1'b0;
`ifdef VEND_CANCEL_EN
        w_next_refund_valid = 1'b0;
        w_next_refund_units = 3'd0;
`endif
        case (r_state)
            COLLECT: begin
`ifdef VEND_CANCEL_EN
                w_coin_ready = !cancel_req;
                if (cancel_req) begin
                    w_next_state        = REFUND;
                    w_next_credit       = 4'd0;
                    w_next_refund_valid = 1'b1;
                    w_next_refund_units = r_credit[2:0];
                end
`else
                w_coin_ready = 1'b1;
`endif
                if (coin_valid && w_coin_ready) begin
                    if (w_invalid) begin
                        w_next_reject = 1'b1;
                    end else begin
                        w_next_credit = w_sum;
                        if (w_sum >= PRICE_UNITS) begin
                            w_next_state = VEND;
                            w_next_hold  = c_HOLD_LOAD;
                        end
                    end
                end
            end
            VEND: begin
                if (r_hold == 4'd0) begin
                    w_next_state  = COLLECT;
                    w_next_credit = 4'd0;
                end else begin
                    w_next_hold = r_hold - 4'd1;
                end
            end
`ifdef VEND_CANCEL_EN
            REFUND: begin
                w_next_state = COLLECT;
            end
`endif
            default: begin
                w_next_state  = COLLECT;
                w_next_credit = 4'd0;
                w_next_hold   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= COLLECT;
            r_credit <= 4'd0;
            r_hold   <= 4'd0;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_credit <= w_next_credit;
            r_hold   <= w_next_hold;
            r_reject <= w_next_reject;
            r_busy   <= (w_next_state == VEND);
        end
    end

`ifdef VEND_CANCEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refund_valid <= 1'b0;
            r_refund_units <= 3'd0;
        end else begin
            r_refund_valid <= w_next_refund_valid;
            r_refund_units <= w_next_refund_units;
        end
    end

    assign refund_valid = r_refund_valid;
    assign refund_units = r_refund_units;
`else
    assign refund_valid = 1'b0;
    assign refund_units = 3'd0;
`endif

    assign coin_ready   = w_coin_ready;
    assign coin_reject  = r_reject;
    assign credit_state = r_credit;
    assign vend_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_credit_fsm
// Description : Directed scoreboard bench for vend_credit_fsm with
//               HOLD_CYCLES=4 (main) and HOLD_CYCLES=1 (second instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_credit_fsm;

    typedef struct {
        int         id;
        logic [3:0] credit;
        logic       busy;
        logic       ready;
        logic       rej;
        logic       rv;
        logic [2:0] ru;
    } exp_t;

    localparam logic [1:0] Q = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] D = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0, coin_valid2 = 1'b0;
    logic [1:0] coin_type = 2'b00, coin_type2 = 2'b00;
    logic       cancel_req = 1'b0;

    logic       coin_ready, coin_reject, refund_valid, vend_busy;
    logic [2:0] refund_units;
    logic [3:0] credit_state;
    logic       coin_ready2, coin_reject2, refund_valid2, vend_busy2;
    logic [2:0] refund_units2;
    logic [3:0] credit_state2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   vec_id = 0;

    always #5 clk = ~clk;

    vend_credit_fsm #(.HOLD_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .coin_ready   (coin_ready),
        .coin_reject  (coin_reject),
`ifdef VEND_CANCEL_EN
        .cancel_req   (cancel_req),
`endif
        .refund_valid (refund_valid),
        .refund_units (refund_units),
        .credit_state (credit_state),
        .vend_busy    (vend_busy)
    );

    vend_credit_fsm #(.HOLD_CYCLES(1)) dut_h1 (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid2),
        .coin_type    (coin_type2),
        .coin_ready   (coin_ready2),
        .coin_reject  (coin_reject2),
`ifdef VEND_CANCEL_EN
        .cancel_req   (1'b0),
`endif
        .refund_valid (refund_valid2),
        .refund_units (refund_units2),
        .credit_state (credit_state2),
        .vend_busy    (vend_busy2)
    );

    // Drive one cycle on the main instance and queue the state expected after the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] t, input logic c,
                        input logic [3:0] cr, input logic b, input logic rdy,
                        input logic rj, input logic rv, input logic [2:0] ru);
        exp_t e;
        @(negedge clk);
        #1;
        rst        = r;
        coin_valid = v;
        coin_type  = t;
        cancel_req = c;
        @(posedge clk);
        vec_id++;
        e.id = vec_id; e.credit = cr; e.busy = b; e.ready = rdy;
        e.rej = rj; e.rv = rv; e.ru = ru;
        q1.push_back(e);
    endtask

    task automatic step2(input logic v, input logic [1:0] t,
                         input logic [3:0] cr, input logic b, input logic rdy);
        exp_t e;
        @(negedge clk);
        #1;
        coin_valid2 = v;
        coin_type2  = t;
        @(posedge clk);
        vec_id++;
        e.id = vec_id; e.credit = cr; e.busy = b; e.ready = rdy;
        e.rej = 1'b0; e.rv = 1'b0; e.ru = 3'd0;
        q2.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            n_checks++;
            if ({credit_state, vend_busy, coin_ready, coin_reject, refund_valid, refund_units} ===
                {e.credit, e.busy, e.ready, e.rej, e.rv, e.ru})
                n_pass++;
            else
                $display("FAIL main_vec%0d got credit=%0d busy=%b ready=%b rej=%b rv=%b ru=%0d exp credit=%0d busy=%b ready=%b rej=%b rv=%b ru=%0d",
                         e.id, credit_state, vend_busy, coin_ready, coin_reject, refund_valid, refund_units,
                         e.credit, e.busy, e.ready, e.rej, e.rv, e.ru);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            n_checks++;
            if ({credit_state2, vend_busy2, coin_ready2, coin_reject2, refund_valid2, refund_units2} ===
                {e.credit, e.busy, e.ready, e.rej, e.rv, e.ru})
                n_pass++;
            else
                $display("FAIL hold1_vec%0d got credit=%0d busy=%b ready=%b rej=%b rv=%b ru=%0d exp credit=%0d busy=%b ready=%b rej=%b rv=%b ru=%0d",
                         e.id, credit_state2, vend_busy2, coin_ready2, coin_reject2, refund_valid2, refund_units2,
                         e.credit, e.busy, e.ready, e.rej, e.rv, e.ru);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //   r  v  t  c   cr b  rdy rj rv ru
        step(1, 0, Q, 0,  0, 0, 1,  0, 0, 0);
        // five quarters: 1..5, vend held 4 cycles, then clear
        step(0, 1, Q, 0,  1, 0, 1,  0, 0, 0);
        step(0, 1, Q, 0,  2, 0, 1,  0, 0, 0);
        step(0, 1, Q, 0,  3, 0, 1,  0, 0, 0);
        step(0, 1, Q, 0,  4, 0, 1,  0, 0, 0);
        step(0, 1, Q, 0,  5, 1, 0,  0, 0, 0);
        step(0, 0, Q, 0,  5, 1, 0,  0, 0, 0);
        step(0, 0, Q, 0,  5, 1, 0,  0, 0, 0);
        step(0, 0, Q, 0,  5, 1, 0,  0, 0, 0);
        step(0, 0, Q, 0,  0, 0, 1,  0, 0, 0);
        // dollar, dollar -> 8; coins offered during the hold are ignored
        step(0, 1, D, 0,  4, 0, 1,  0, 0, 0);
        step(0, 1, D, 0,  8, 1, 0,  0, 0, 0);
        step(0, 1, Q, 0,  8, 1, 0,  0, 0, 0);
        step(0, 1, X, 0,  8, 1, 0,  0, 0, 0);
        step(0, 1, D, 0,  8, 1, 0,  0, 0, 0);
        step(0, 1, Q, 0,  0, 0, 1,  0, 0, 0);
        // half, invalid, half
        step(0, 1, H, 0,  2, 0, 1,  0, 0, 0);
        step(0, 1, X, 0,  2, 0, 1,  1, 0, 0);
        step(0, 1, H, 0,  4, 0, 1,  0, 0, 0);
        // reset beats a concurrent dollar
        step(1, 1, D, 0,  0, 0, 1,  0, 0, 0);
        // reach 7, reset on the second vend cycle
        step(0, 1, Q, 0,  1, 0, 1,  0, 0, 0);
        step(0, 1, H, 0,  3, 0, 1,  0, 0, 0);
        step(0, 1, D, 0,  7, 1, 0,  0, 0, 0);
        step(0, 0, Q, 0,  7, 1, 0,  0, 0, 0);
        step(1, 0, Q, 0,  0, 0, 1,  0, 0, 0);
        step(0, 0, Q, 0,  0, 0, 1,  0, 0, 0);
`ifdef VEND_CANCEL_EN
        // cancel with a simultaneous quarter: refund 3, quarter not consumed
        step(0, 1, Q, 0,  1, 0, 1,  0, 0, 0);
        step(0, 1, H, 0,  3, 0, 1,  0, 0, 0);
        step(0, 1, Q, 1,  0, 0, 0,  0, 1, 3);
        step(0, 0, Q, 0,  0, 0, 1,  0, 0, 0);
        // cancel at zero credit
        step(0, 0, Q, 1,  0, 0, 0,  0, 1, 0);
        step(0, 0, Q, 0,  0, 0, 1,  0, 0, 0);
        // cancel ignored during vend
        step(0, 1, D, 0,  4, 0, 1,  0, 0, 0);
        step(0, 1, D, 0,  8, 1, 0,  0, 0, 0);
        step(0, 0, Q, 1,  8, 1, 0,  0, 0, 0);
        step(0, 0, Q, 1,  8, 1, 0,  0, 0, 0);
        step(0, 0, Q, 1,  8, 1, 0,  0, 0, 0);
        step(0, 0, Q, 0,  0, 0, 1,  0, 0, 0);
`endif
        // HOLD_CYCLES=1 instance: three halves -> 6 for one cycle
        step2(1, H,  2, 0, 1);
        step2(1, H,  4, 0, 1);
        step2(1, H,  6, 1, 0);
        step2(0, Q,  0, 0, 1);
        step2(0, Q,  0, 0, 1);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q1.size() == 0 && q2.size() == 0)
            n_pass++;
        else
            $display("FAIL drain got pending=%0d required pending=0", q1.size() + q2.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
